uart_hex_console: RTL and testbench

Parametrised byte console between the UART core's FIFO interface and an N-digit multiplexed 7-segment display. It pops received bytes and keeps a hex history of the newest DIGITS/2 bytes on the display. On a button tick it replays that history over TX, oldest byte first. With ECHO=1 it also loops every received byte straight back to TX. It replaces the fixed four-digit, display-only top-level arrangement.

---
 rtl/uart_hex_console.sv | 138 +++++++++++++
 tb/tb_uart_hex_console.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_console.sv
// Byte console between the UART FIFOs and a multiplexed 7-segment display:
// keeps a hex history of the newest bytes, replays it over TX on request.
module uart_hex_console #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int ECHO     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  input  logic              send_tick,
  input  logic              clear_tick,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              busy
);

  localparam int BYTES = DIGITS / 2;
  localparam int HW    = BYTES * 8;
  localparam int VW    = $clog2(BYTES + 1);
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SW    = $clog2(SCAN_DIV);
  localparam int DW    = $clog2(DIGITS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [HW-1:0]   hist;
  logic [HW-1:0]   shadow;
  logic [VW-1:0]   vcnt;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   scan_cnt;
  logic [DW-1:0]   digit;
  logic [DW-1:0]   byte_k;
  logic [7:0]      sel_byte;
  logic [3:0]      nib;
  logic [6:0]      hex;

  // Echo only pops when the byte can be forwarded in the same cycle.
  always_comb begin
    rd_uart = !rst && !rx_empty && (ECHO == 0 || (state == IDLE && !tx_full));
    wr_uart = 1'b0;
    w_data  = 8'h00;
    if (!rst) begin
      if (state == SEND) begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = shadow[8*idx +: 8];
        end
      end else if (ECHO != 0 && rd_uart) begin
        wr_uart = 1'b1;
        w_data  = r_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hist     <= '0;
      shadow   <= '0;
      vcnt     <= '0;
      idx      <= '0;
      scan_cnt <= '0;
      digit    <= '0;
    end else begin
      if (clear_tick)
        vcnt <= rd_uart ? VW'(1) : '0;
      else if (rd_uart && vcnt != VW'(BYTES))
        vcnt <= vcnt + VW'(1);

      if (rd_uart)
        hist <= (hist << 8) | HW'(r_data);

      case (state)
        IDLE: begin
          if (send_tick && vcnt != '0) begin
            shadow <= hist;
            idx    <= IW'(vcnt - VW'(1));
            state  <= SEND;
          end
        end
        SEND: begin
          if (!tx_full) begin
            if (idx == '0) state <= IDLE;
            else           idx   <= idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= (digit == DW'(DIGITS - 1)) ? '0 : digit + DW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  assign busy     = (state == SEND);
  assign byte_k   = digit >> 1;
  assign sel_byte = hist[8*byte_k +: 8];
  assign nib      = digit[0] ? sel_byte[7:4] : sel_byte[3:0];

  always_comb begin
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  end

  // Digits of bytes not yet received stay dark.
  assign seg = (32'(byte_k) >= 32'(vcnt)) ? 7'h7F : hex;
  assign an  = ~(DIGITS'(1) << digit);
  assign dp  = !(busy && !digit[0]);

endmodule

// File: tb/tb_uart_hex_console.sv
// Directed bench for uart_hex_console: display, replay, stall, clear, echo.
module tb_uart_hex_console;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty, tx_full, send_tick, clear_tick;
  logic [7:0] r_data;
  logic       rd_uart, wr_uart, dp, busy;
  logic [7:0] w_data;
  logic [3:0] an;
  logic [6:0] seg;

  logic       e_rx_empty, e_tx_full, e_send, e_clear;
  logic [7:0] e_r_data;
  logic       e_rd, e_wr, e_dp, e_busy;
  logic [7:0] e_wdata;
  logic [3:0] e_an;
  logic [6:0] e_seg;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_hex_console #(.DIGITS(4), .SCAN_DIV(4), .ECHO(0)) u_dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .send_tick(send_tick),
    .clear_tick(clear_tick), .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  uart_hex_console #(.DIGITS(4), .SCAN_DIV(4), .ECHO(1)) u_echo (
    .clk(clk), .rst(rst), .rx_empty(e_rx_empty), .r_data(e_r_data), .rd_uart(e_rd),
    .tx_full(e_tx_full), .wr_uart(e_wr), .w_data(e_wdata), .send_tick(e_send),
    .clear_tick(e_clear), .an(e_an), .seg(e_seg), .dp(e_dp), .busy(e_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for digit d to be selected, then check its segments.
  task automatic show(input int d, input logic [6:0] exp_seg);
    logic [3:0] want;
    want = 4'b0001 << d;
    want = ~want;
    for (int i = 0; i < 40 && an !== want; i++) @(negedge clk);
    #1;
    check($sformatf("an_sel%0d", d), an, want);
    check($sformatf("seg_d%0d", d), seg, exp_seg);
  endtask

  task automatic pop_hold(input logic [7:0] b);
    rx_empty = 1'b0;
    r_data   = b;
    #1;
    check("rd_pulse", rd_uart, 1'b1);
    @(negedge clk);
  endtask

  task automatic pop_end();
    rx_empty = 1'b1;
    #1;
    check("rd_idle", rd_uart, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_an;
    rst = 1'b1; rx_empty = 1'b1; tx_full = 1'b0; send_tick = 1'b0; clear_tick = 1'b0;
    r_data = 8'h00;
    e_rx_empty = 1'b1; e_tx_full = 1'b0; e_send = 1'b0; e_clear = 1'b0; e_r_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_rd", rd_uart, 1'b0);
    check("rst_wr", wr_uart, 1'b0);
    check("rst_wdata", w_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_e_an", e_an, 4'b1110);
    check("rst_e_wr", e_wr, 1'b0);

    // Scan order and dwell: digit = (cycles/4) mod 4, all blank.
    for (int k = 0; k < 20; k++) begin
      exp_an = 4'b0001 << ((k / 4) % 4);
      exp_an = ~exp_an;
      check("scan_an", an, exp_an);
      check("scan_seg", seg, 7'h7F);
      check("scan_dp", dp, 1'b1);
      check("scan_rd", rd_uart, 1'b0);
      check("scan_wr", wr_uart, 1'b0);
      @(negedge clk);
      #1;
    end

    pop_hold(8'h41);
    pop_end();
    show(0, 7'h79);
    show(1, 7'h19);
    show(2, 7'h7F);
    show(3, 7'h7F);

    pop_hold(8'h12);
    pop_hold(8'h34);
    pop_hold(8'h56);
    pop_end();
    show(0, 7'h02);
    show(1, 7'h12);
    show(2, 7'h19);
    show(3, 7'h30);

    // Replay {34,56}, oldest first, no stall.
    send_tick = 1'b1;
    #1;
    check("rp_busy0", busy, 1'b0);
    check("rp_wr0", wr_uart, 1'b0);
    @(negedge clk);
    send_tick = 1'b0;
    #1;
    check("rp_busy1", busy, 1'b1);
    check("rp_wr1", wr_uart, 1'b1);
    check("rp_data1", w_data, 8'h34);
    check("rp_dp", dp, (an[0] == 1'b0 || an[2] == 1'b0) ? 1'b0 : 1'b1);
    @(negedge clk);
    #1;
    check("rp_busy2", busy, 1'b1);
    check("rp_wr2", wr_uart, 1'b1);
    check("rp_data2", w_data, 8'h56);
    @(negedge clk);
    #1;
    check("rp_busy3", busy, 1'b0);
    check("rp_wr3", wr_uart, 1'b0);
    check("rp_dp3", dp, 1'b1);

    // Replay with a 5-cycle stall and a pop of 0x99 during SEND.
    send_tick = 1'b1;
    @(negedge clk);
    send_tick = 1'b0;
    #1;
    check("st_wr1", wr_uart, 1'b1);
    check("st_data1", w_data, 8'h34);
    @(negedge clk);
    tx_full  = 1'b1;
    rx_empty = 1'b0;
    r_data   = 8'h99;
    #1;
    check("st_pop", rd_uart, 1'b1);
    check("st_hold_wr", wr_uart, 1'b0);
    @(negedge clk);
    rx_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("st_hold_wr", wr_uart, 1'b0);
      check("st_hold_busy", busy, 1'b1);
      @(negedge clk);
    end
    tx_full = 1'b0;
    #1;
    check("st_wr2", wr_uart, 1'b1);
    check("st_data2", w_data, 8'h56);
    @(negedge clk);
    #1;
    check("st_busy_end", busy, 1'b0);
    check("st_wr_end", wr_uart, 1'b0);
    show(0, 7'h10);
    show(1, 7'h10);
    show(2, 7'h02);
    show(3, 7'h12);

    // Echo instance: forward in the same cycle; no pop while TX is full.
    e_rx_empty = 1'b0;
    e_r_data   = 8'hAB;
    #1;
    check("echo_rd", e_rd, 1'b1);
    check("echo_wr", e_wr, 1'b1);
    check("echo_data", e_wdata, 8'hAB);
    @(negedge clk);
    e_tx_full = 1'b1;
    e_r_data  = 8'hCD;
    #1;
    check("echo_full_rd", e_rd, 1'b0);
    check("echo_full_wr", e_wr, 1'b0);
    @(negedge clk);
    e_rx_empty = 1'b1;
    e_tx_full  = 1'b0;

    // Reset in the middle of a replay of {56,99}.
    send_tick = 1'b1;
    @(negedge clk);
    send_tick = 1'b0;
    #1;
    check("ab_wr1", wr_uart, 1'b1);
    check("ab_data1", w_data, 8'h56);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ab_wr_rst", wr_uart, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ab_busy", busy, 1'b0);
    check("ab_wr_after", wr_uart, 1'b0);
    @(negedge clk);
    #1;
    check("ab_wr_after2", wr_uart, 1'b0);

    // Clear, ignored empty send, then clear together with a pop.
    pop_hold(8'hC7);
    pop_end();
    show(0, 7'h78);
    show(1, 7'h46);
    clear_tick = 1'b1;
    @(negedge clk);
    clear_tick = 1'b0;
    show(0, 7'h7F);
    show(1, 7'h7F);
    send_tick = 1'b1;
    @(negedge clk);
    send_tick = 1'b0;
    #1;
    check("empty_send_busy", busy, 1'b0);
    check("empty_send_wr", wr_uart, 1'b0);

    pop_hold(8'hEE);
    pop_hold(8'h0F);
    clear_tick = 1'b1;
    pop_hold(8'hD2);
    clear_tick = 1'b0;
    pop_end();
    show(0, 7'h24);
    show(1, 7'h21);
    show(2, 7'h7F);
    show(3, 7'h7F);
    send_tick = 1'b1;
    @(negedge clk);
    send_tick = 1'b0;
    #1;
    check("one_wr", wr_uart, 1'b1);
    check("one_data", w_data, 8'hD2);
    @(negedge clk);
    #1;
    check("one_busy_end", busy, 1'b0);
    check("one_wr_end", wr_uart, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
